axil_read_engine: RTL and testbench

AXI4-Lite read-path slave with multiple outstanding reads. The block accepts AR requests, issues single-cycle read strobes to the register/memory backend, and buffers in-order backend returns in a response FIFO. It presents those returns on the R channel with full RVALID/RREADY backpressure. Outstanding depth and all widths are parametrised. It replaces the single-outstanding read path and sits between the AXI4-Lite interconnect and the slave memory.

---
 rtl/axil_pkg.sv | 14 +
 rtl/axil_resp_fifo.sv | 55 +++++
 rtl/axil_read_engine.sv | 107 ++++++++++
 tb/tb_axil_read_engine.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite read-path constants and sizing helpers.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Pointer width for a power-of-2 depth; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/axil_resp_fifo.sv
// Response FIFO with a registered head: the entry at the head is presented
// from a flop so RDATA/RRESP never see a memory-read path.
module axil_resp_fifo
  import axil_pkg::*;
#(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full
);
  localparam int PW = ptr_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_head;
  logic [PW-1:0]    r_wr, r_rd, w_rd_nxt;
  logic [PW:0]      r_cnt, w_cnt_nxt;
  logic             w_push, w_pop;

  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == (PW+1)'(DEPTH));
  assign w_push    = i_push & ~o_full;
  assign w_pop     = i_pop & ~o_empty;
  assign w_rd_nxt  = w_pop ? r_rd + PW'(1) : r_rd;
  assign w_cnt_nxt = r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
  assign o_head    = r_head;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_head <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_rd  <= w_rd_nxt;
      if (w_push) r_wr <= r_wr + PW'(1);
      // Next head is the entry being written when the FIFO drains to it.
      if (w_cnt_nxt == '0)                   r_head <= '0;
      else if (w_push && (w_rd_nxt == r_wr)) r_head <= i_din;
      else                                   r_head <= r_mem[w_rd_nxt];
    end
  end

endmodule

// File: rtl/axil_read_engine.sv
// AXI4-Lite read slave with up to MAX_OUTSTANDING reads in flight.
// Optional counters enabled by defining AXIL_RD_STATS_EN.
module axil_read_engine
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 5,
  parameter int RESP_WIDTH      = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STAT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ARVALID,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARREADY,
  output logic                  REN,
  output logic [ADDR_WIDTH-1:0] ARADDROUT,
  input  logic                  MREADY,
  input  logic [DATA_WIDTH-1:0] MDATA,
  input  logic [RESP_WIDTH-1:0] MRESP,
  output logic                  RVALID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [RESP_WIDTH-1:0] RRESP,
  input  logic                  RREADY
`ifdef AXIL_RD_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] RD_CNT,
  output logic [STAT_WIDTH-1:0] RD_ERR_CNT
`endif
);
  localparam int          PW     = ptr_w(MAX_OUTSTANDING);
  localparam logic [PW:0] MAX_CR = (PW+1)'(MAX_OUTSTANDING);

  if (MAX_OUTSTANDING < 2 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0)
    $error("MAX_OUTSTANDING must be a power of 2 and >= 2");
  if (STAT_WIDTH < 1 || RESP_WIDTH < 2)
    $error("STAT_WIDTH must be >= 1 and RESP_WIDTH >= 2");

  logic                  r_arready, r_ren;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [PW:0]           r_credit, w_credit_nxt, r_mpend, w_mpend_nxt;
  logic                  w_ar_hs, w_r_hs, w_mret, w_empty, w_full;
  logic [DATA_WIDTH+RESP_WIDTH-1:0] w_head;

  assign w_ar_hs      = ARVALID & r_arready;
  assign w_r_hs       = RVALID & RREADY;
  // A return with nothing issued is spurious and must not reach the FIFO.
  assign w_mret       = MREADY & (r_mpend != '0) & ~w_full;
  assign w_credit_nxt = r_credit + (PW+1)'(w_ar_hs) - (PW+1)'(w_r_hs);
  assign w_mpend_nxt  = r_mpend + (PW+1)'(r_ren) - (PW+1)'(w_mret);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_arready <= 1'b0;
      r_ren     <= 1'b0;
      r_araddr  <= '0;
      r_credit  <= '0;
      r_mpend   <= '0;
    end else begin
      r_credit  <= w_credit_nxt;
      r_mpend   <= w_mpend_nxt;
      r_arready <= (w_credit_nxt < MAX_CR);
      r_ren     <= w_ar_hs;
      if (w_ar_hs) r_araddr <= ARADDR;
    end
  end

  axil_resp_fifo #(
    .WIDTH(DATA_WIDTH + RESP_WIDTH),
    .DEPTH(MAX_OUTSTANDING)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (resetn),
    .i_push (w_mret),
    .i_din  ({MDATA, MRESP}),
    .i_pop  (w_r_hs),
    .o_head (w_head),
    .o_empty(w_empty),
    .o_full (w_full)
  );

  assign ARREADY        = r_arready;
  assign REN            = r_ren;
  assign ARADDROUT      = r_araddr;
  assign RVALID         = ~w_empty;
  assign {RDATA, RRESP} = w_head;

`ifdef AXIL_RD_STATS_EN
  logic [STAT_WIDTH-1:0] r_rd_cnt, r_err_cnt;

  // SLVERR and DECERR both carry bit 1 set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_cnt  <= '0;
      r_err_cnt <= '0;
    end else if (w_r_hs) begin
      if (~&r_rd_cnt)              r_rd_cnt  <= r_rd_cnt + 1'b1;
      if (RRESP[1] && ~&r_err_cnt) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign RD_CNT     = r_rd_cnt;
  assign RD_ERR_CNT = r_err_cnt;
`endif

endmodule

// File: tb/tb_axil_read_engine.sv
// Bench for axil_read_engine: cycle table, directed sequences, random traffic
// against an in-order read model. Honours AXIL_RD_STATS_EN.
module tb_axil_read_engine;
  localparam int DW = 32, AW = 5, RW = 2, MAXO = 4, SW = 16;

  logic          clk = 1'b0, resetn = 1'b0;
  logic          ARVALID = 1'b0, ARREADY, REN, MREADY = 1'b0, RVALID, RREADY = 1'b0;
  logic [AW-1:0] ARADDR = '0, ARADDROUT;
  logic [DW-1:0] MDATA = '0, RDATA;
  logic [RW-1:0] MRESP = '0, RRESP;
`ifdef AXIL_RD_STATS_EN
  logic [SW-1:0] RD_CNT, RD_ERR_CNT;
`endif

  axil_read_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW),
                     .MAX_OUTSTANDING(MAXO), .STAT_WIDTH(SW)) dut (
    .clk(clk), .resetn(resetn), .ARVALID(ARVALID), .ARADDR(ARADDR), .ARREADY(ARREADY),
    .REN(REN), .ARADDROUT(ARADDROUT), .MREADY(MREADY), .MDATA(MDATA), .MRESP(MRESP),
    .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RREADY(RREADY)
`ifdef AXIL_RD_STATS_EN
    , .RD_CNT(RD_CNT), .RD_ERR_CNT(RD_ERR_CNT)
`endif
  );

  always #5 clk = ~clk;

  int n_tot = 0, n_pass = 0;

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
  endfunction

  // Backend memory image: data and response are pure functions of address.
  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return 32'hA0 + 32'(a) * 32'h0001_1001;
  endfunction
  function automatic logic [RW-1:0] resp_of(input logic [AW-1:0] a);
    return a[4:3];
  endfunction

  // Reference model: reads complete in acceptance order.
  typedef struct packed { logic [DW-1:0] d; logic [RW-1:0] r; } rsp_t;
  rsp_t          rq[$];      // returned, awaiting R handshake
  logic [AW-1:0] bq[$];      // issued to backend, awaiting return
  int            outst;      // accepted, not yet R-handshaken
  bit            ren_exp, fresh, g_ar_hs;
  logic [AW-1:0] ren_addr;
  int            m_cnt, m_err;

  task automatic tick(input bit av, input logic [AW-1:0] aa, input bit rr,
                      input int mpct, input bit spur);
    bit mr, rv;
    logic [AW-1:0] ma;
    chk("arready", ARREADY, (!fresh && outst < MAXO));
    chk("ren", REN, ren_exp);
    if (REN && ren_exp) begin
      chk("araddrout", ARADDROUT, ren_addr);
      bq.push_back(ren_addr);
    end
    rv = (rq.size() > 0);
    chk("rvalid", RVALID, rv);
    if (rv) begin
      chk("rdata", RDATA, rq[0].d);
      chk("rresp", RRESP, rq[0].r);
    end
`ifdef AXIL_RD_STATS_EN
    chk("rd_cnt", RD_CNT, m_cnt);
    chk("rd_err_cnt", RD_ERR_CNT, m_err);
`endif
    // Backend may only answer REN strobes from earlier cycles.
    mr = ((bq.size() - (REN ? 1 : 0)) > 0) && ($urandom_range(99) < mpct);
    MREADY = mr;
    MDATA  = $urandom;
    MRESP  = RW'($urandom);
    if (mr) begin
      ma = bq.pop_front();
      MDATA = data_of(ma);
      MRESP = resp_of(ma);
    end else if (spur && bq.size() == 0) MREADY = 1'b1;
    ARVALID = av; ARADDR = aa; RREADY = rr;
    g_ar_hs = av && ARREADY;
    ren_exp = g_ar_hs;
    if (g_ar_hs) begin
      ren_addr = aa;
      outst++;
    end
    if (rr && RVALID && rv) begin
      if (m_cnt < 65535) m_cnt++;
      if (rq[0].r[1] && m_err < 65535) m_err++;
      void'(rq.pop_front());
      outst--;
    end
    if (mr) rq.push_back('{d: MDATA, r: MRESP});
    fresh = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;
    MREADY = 1'b1; MDATA = $urandom; MRESP = 2'b11;
    #1;
    chk("rst_arready", ARREADY, 0);
    chk("rst_ren", REN, 0);
    chk("rst_araddrout", ARADDROUT, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_rresp", RRESP, 0);
`ifdef AXIL_RD_STATS_EN
    chk("rst_rd_cnt", RD_CNT, 0);
    chk("rst_rd_err_cnt", RD_ERR_CNT, 0);
`endif
    rq.delete(); bq.delete();
    outst = 0; ren_exp = 0; m_cnt = 0; m_err = 0;
    repeat (2) @(negedge clk);
    MREADY = 1'b0; resetn = 1'b1; fresh = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (outst > 0 || rq.size() > 0 || bq.size() > 0 || ren_exp); i++)
      tick(1'b0, '0, 1'b1, 100, 1'b0);
    chk("drain_outstanding", outst, 0);
  endtask

  typedef struct {
    bit av; logic [AW-1:0] aa; bit mr; logic [DW-1:0] md; logic [RW-1:0] ms; bit rr;
    bit e_ar; bit e_ren; logic [AW-1:0] e_ao; bit e_rv; logic [DW-1:0] e_rd; logic [RW-1:0] e_rs;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int acc;
    //          av  aa     mr  md            ms     rr | ar ren ao     rv rd            rs
    tbl[0]  = '{1, 5'h04, 0, 32'h0,        2'b00, 0,  0, 0, 5'h00, 0, 32'h0,        2'b00};
    tbl[1]  = '{1, 5'h04, 0, 32'h0,        2'b00, 0,  1, 0, 5'h00, 0, 32'h0,        2'b00};
    tbl[2]  = '{0, 5'h00, 0, 32'h0,        2'b00, 0,  1, 1, 5'h04, 0, 32'h0,        2'b00};
    tbl[3]  = '{0, 5'h00, 1, 32'hDEADBEEF, 2'b00, 1,  1, 0, 5'h04, 0, 32'h0,        2'b00};
    tbl[4]  = '{0, 5'h00, 0, 32'h0,        2'b00, 1,  1, 0, 5'h04, 1, 32'hDEADBEEF, 2'b00};
    tbl[5]  = '{1, 5'h1C, 0, 32'h0,        2'b00, 0,  1, 0, 5'h04, 0, 32'h0,        2'b00};
    tbl[6]  = '{0, 5'h00, 0, 32'h0,        2'b00, 0,  1, 1, 5'h1C, 0, 32'h0,        2'b00};
    tbl[7]  = '{0, 5'h00, 1, 32'h00001234, 2'b10, 0,  1, 0, 5'h1C, 0, 32'h0,        2'b00};
    tbl[8]  = '{0, 5'h00, 0, 32'h0,        2'b00, 0,  1, 0, 5'h1C, 1, 32'h00001234, 2'b10};
    tbl[9]  = '{0, 5'h00, 0, 32'h0,        2'b00, 1,  1, 0, 5'h1C, 1, 32'h00001234, 2'b10};
    tbl[10] = '{0, 5'h00, 1, 32'hFFFFFFFF, 2'b11, 1,  1, 0, 5'h1C, 0, 32'h0,        2'b00};
    tbl[11] = '{0, 5'h00, 0, 32'h0,        2'b00, 1,  1, 0, 5'h1C, 0, 32'h0,        2'b00};

    repeat (2) @(negedge clk);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("tbl%0d_arready", i), ARREADY, tbl[i].e_ar);
      chk($sformatf("tbl%0d_ren", i), REN, tbl[i].e_ren);
      chk($sformatf("tbl%0d_araddrout", i), ARADDROUT, tbl[i].e_ao);
      chk($sformatf("tbl%0d_rvalid", i), RVALID, tbl[i].e_rv);
      if (tbl[i].e_rv) begin
        chk($sformatf("tbl%0d_rdata", i), RDATA, tbl[i].e_rd);
        chk($sformatf("tbl%0d_rresp", i), RRESP, tbl[i].e_rs);
      end
      ARVALID = tbl[i].av; ARADDR = tbl[i].aa; MREADY = tbl[i].mr;
      MDATA = tbl[i].md; MRESP = tbl[i].ms; RREADY = tbl[i].rr;
      @(negedge clk);
    end
`ifdef AXIL_RD_STATS_EN
    chk("tbl_rd_cnt", RD_CNT, 2);
    chk("tbl_rd_err_cnt", RD_ERR_CNT, 1);
`endif

    // Outstanding limit, then backpressured drain in order.
    do_reset();
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      tick(acc < 5, AW'(acc * 4), 1'b0, 100, 1'b0);
      if (g_ar_hs) acc++;
    end
    chk("ol_accepted", acc, 4);
    chk("ol_arready_full", ARREADY, 0);
    tick(1'b1, AW'(acc * 4), 1'b1, 100, 1'b0);
    if (g_ar_hs) acc++;
    chk("ol_arready_reopen", ARREADY, 1);
    tick(1'b1, AW'(acc * 4), 1'b0, 100, 1'b0);
    if (g_ar_hs) acc++;
    chk("ol_fifth_accepted", acc, 5);
    for (int i = 0; i < 8; i++) tick(1'b0, '0, (i % 2) == 0, 100, 1'b0);
    drain();

    // Spurious backend return with nothing outstanding.
    for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b1, 0, 1'b1);
    chk("spur_outstanding", outst, 0);

    // Reset with three reads in flight, then a clean read of 0x08.
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      tick(acc < 3, AW'(8 + acc), 1'b0, 0, 1'b0);
      if (g_ar_hs) acc++;
    end
    chk("mid_accepted", acc, 3);
    do_reset();
    acc = 0;
    for (int i = 0; i < 4 && acc == 0; i++) begin
      tick(1'b1, 5'h08, 1'b1, 100, 1'b0);
      if (g_ar_hs) acc++;
    end
    chk("post_rst_accepted", acc, 1);
    drain();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(99) < 60, AW'($urandom), $urandom_range(99) < 65,
           $urandom_range(20, 90), $urandom_range(99) < 10);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
